// File: rtl/ifu.sv
// Instruction fetch unit: fetches one word, holds it while it executes,
// then computes the next pc from sequential, branch or jump flow.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        stall,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  OP,
  output logic [5:0]  Funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;

  logic [1:0]  state;
  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] jmp_tgt;
  logic [31:0] next_pc;

  // Decode fields and the memory request straight from the registers
  always_comb begin
    OP          = instr[31:26];
    Funct       = instr[5:0];
    pc_plus4    = pc + 32'd4;
    imem_req    = (state == FETCH);
    imem_addr   = pc;
    instr_valid = (state == EXEC);
  end

  // Next pc: jump beats a taken branch, which beats fall-through
  always_comb begin
    br_off  = {{14{instr[15]}}, instr[15:0], 2'b00};
    br_tgt  = pc_plus4 + br_off;
    jmp_tgt = {pc_plus4[31:28], instr[25:0], 2'b00};
    next_pc = pc_plus4;
    if (Jump) begin
      next_pc = jmp_tgt;
    end else if (Branch && Zero) begin
      next_pc = br_tgt;
    end
  end

  // Fetch/execute sequencing; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= {RESET_PC[31:2], 2'b00};
      instr <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
        end
        FETCH: begin
          if (imem_ready) begin
            instr <= imem_rdata;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (!stall) begin
            pc    <= next_pc;
            state <= FETCH;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed scenarios with literal expectations, then
// random traffic checked every cycle against a transaction-level model.
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        Jump;
  logic        Branch;
  logic        Zero;
  logic        stall;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  OP;
  logic [5:0]  Funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  int checks = 0;
  int errors = 0;

  // model: what the unit is doing, which word it holds, where it is
  bit          m_waiting;
  bit          m_running;
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  localparam logic [31:0] NOP = 32'h0000_0020;

  ifu dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .Jump(Jump), .Branch(Branch), .Zero(Zero), .stall(stall),
    .instr(instr), .instr_valid(instr_valid),
    .OP(OP), .Funct(Funct), .pc(pc), .pc_plus4(pc_plus4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] target();
    int off;
    logic [31:0] seq;
    seq = m_pc + 32'd4;
    off = $signed(m_instr[15:0]);
    if (Jump)
      return {seq[31:28], m_instr[25:0], 2'b00};
    if (Branch && Zero)
      return seq + 32'(off * 4);
    return seq;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_waiting = 0;
      m_running = 0;
      m_pc      = 32'h0000_3000;
      m_instr   = 32'h0;
    end else if (!m_waiting && !m_running) begin
      m_waiting = 1;
    end else if (m_waiting) begin
      if (imem_ready) begin
        m_instr   = imem_rdata;
        m_waiting = 0;
        m_running = 1;
      end
    end else if (!stall) begin
      m_pc      = target();
      m_running = 0;
      m_waiting = 1;
    end
  endtask

  task automatic compare();
    logic [31:0] p4;
    p4 = m_pc + 32'd4;
    chk("req", {31'd0, imem_req}, {31'd0, m_waiting});
    chk("valid", {31'd0, instr_valid}, {31'd0, m_running});
    chk("addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("instr", instr, m_instr);
    chk("pc_plus4", pc_plus4, p4);
    chk("OP", {26'd0, OP}, {26'd0, m_instr[31:26]});
    chk("Funct", {26'd0, Funct}, {26'd0, m_instr[5:0]});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic set_in(input bit rdy, input logic [31:0] rd,
                        input bit j, input bit b, input bit z,
                        input bit st);
    imem_ready = rdy;
    imem_rdata = rd;
    Jump       = j;
    Branch     = b;
    Zero       = z;
    stall      = st;
  endtask

  task automatic fe(input logic [31:0] w, input bit j,
                    input bit b, input bit z);
    set_in(1, w, 0, 0, 0, 0);
    step();
    set_in(0, 32'hA5A5_A5A5, j, b, z, 0);
    step();
  endtask

  initial begin
    rst_n = 0;
    set_in(1, 32'h1111_1111, 0, 0, 0, 0);
    step();
    step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_instr", instr, 32'h0);

    rst_n = 1;
    step();
    chk("seq_a0", imem_addr, 32'h0000_3000);
    chk("seq_req", {31'd0, imem_req}, 32'd1);
    set_in(1, NOP, 0, 0, 0, 0);
    step();
    chk("seq_v1", {31'd0, instr_valid}, 32'd1);
    chk("seq_q1", {31'd0, imem_req}, 32'd0);
    step();
    chk("seq_v0", {31'd0, instr_valid}, 32'd0);
    chk("seq_a1", imem_addr, 32'h0000_3004);
    fe(NOP, 0, 0, 0);
    chk("seq_a2", imem_addr, 32'h0000_3008);
    fe(NOP, 0, 0, 0);
    fe(NOP, 0, 0, 0);
    chk("pre_br", imem_addr, 32'h0000_3010);

    fe(32'h1000_FFFE, 0, 1, 1);
    chk("br_taken", imem_addr, 32'h0000_300C);
    fe(NOP, 0, 0, 0);
    fe(32'h1000_FFFE, 0, 1, 0);
    chk("br_not", imem_addr, 32'h0000_3014);
    fe(NOP, 0, 0, 0);
    fe(NOP, 0, 0, 0);
    fe(NOP, 0, 0, 0);
    chk("pre_jal", imem_addr, 32'h0000_3020);

    set_in(1, 32'h0C00_0C00, 0, 0, 0, 0);
    step();
    chk("jal_p4", pc_plus4, 32'h0000_3024);
    chk("jal_op", {26'd0, OP}, 32'h3);
    set_in(0, 32'h0, 1, 1, 1, 0);
    step();
    chk("jal_tgt", imem_addr, 32'h0000_3000);

    fe(32'h1000_F3FE, 0, 1, 1);
    chk("wrap_pc", imem_addr, 32'hFFFF_FFFC);
    set_in(1, NOP, 0, 0, 0, 0);
    step();
    chk("wrap_p4", pc_plus4, 32'h0000_0000);
    set_in(0, 32'h0, 0, 0, 0, 0);
    step();
    chk("wrap_next", imem_addr, 32'h0000_0000);

    for (int i = 0; i < 5; i++) begin
      set_in(0, $urandom, 0, 0, 0, 0);
      step();
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, 32'h0000_0000);
      chk("wait_instr", instr, NOP);
    end
    set_in(1, 32'h2468_ACE0, 0, 0, 0, 0);
    step();
    chk("stall_v0", {31'd0, instr_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      set_in(1, 32'h0, 1, 0, 0, 1);
      step();
      chk("stall_v", {31'd0, instr_valid}, 32'd1);
      chk("stall_pc", pc, 32'h0000_0000);
      chk("stall_in", instr, 32'h2468_ACE0);
    end
    set_in(0, 32'h0, 0, 0, 0, 0);
    step();
    chk("stall_end", imem_addr, 32'h0000_0004);

    set_in(0, 32'h0, 0, 0, 0, 0);
    step();
    rst_n = 0;
    set_in(1, 32'hDEAD_BEEF, 0, 0, 0, 0);
    step();
    chk("rr_instr", instr, 32'h0);
    chk("rr_pc", pc, 32'h0000_3000);
    chk("rr_req", {31'd0, imem_req}, 32'd0);
    chk("rr_valid", {31'd0, instr_valid}, 32'd0);
    rst_n = 1;

    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      set_in($urandom_range(0, 9) < 7, $urandom,
             $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
